// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage operand forwarding
// and load-use hazard detection for the 16-bit pipeline.
// Optional feature macro: IDEX_FORWARD_EN
//   defined   -> EX/MEM and MEM/WB bypass into the ALU operands; stall only on load-use
//   undefined -> no bypass; stall on any pending write from EX or EX/MEM
module id_ex_stage #(
  parameter int DW   = 16,
  parameter int RAW_ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [RAW_-1:0] id_rs,
  input  logic [RAW_-1:0] id_rt,
  input  logic [RAW_-1:0] id_rd,
  input  logic [7:0]      id_imm,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RAW_-1:0] exmem_rd,
  input  logic [DW-1:0]   exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RAW_-1:0] memwb_rd,
  input  logic [DW-1:0]   memwb_result,
  output logic            stall,
  output logic            ex_valid,
  output logic [DW-1:0]   alu_in1,
  output logic [DW-1:0]   alu_in2,
  output logic [2:0]      ex_alu_control,
  output logic [DW-1:0]   ex_store_data,
  output logic [RAW_-1:0] ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg
);

  logic [DW-1:0]   rs_data_q;
  logic [DW-1:0]   rt_data_q;
  logic [RAW_-1:0] rs_q;
  logic [RAW_-1:0] rt_q;
  logic [RAW_-1:0] rd_q;
  logic [DW-1:0]   imm_q;
  logic [2:0]      alu_control_q;
  logic            alu_src_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            reg_write_q;
  logic            mem_to_reg_q;
  logic            valid_q;
  logic [DW-1:0]   imm_ext;
  logic [DW-1:0]   fwd_a;
  logic [DW-1:0]   fwd_b;
  logic            hz;

  // LUI takes the immediate zero-extended, everything else sign-extends bit 7
  always_comb begin
    imm_ext = {{(DW-8){id_imm[7]}}, id_imm};
    if (id_alu_control == 3'b110)
      imm_ext = {{(DW-8){1'b0}}, id_imm};
  end

`ifdef IDEX_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = 1'b0;

  // Only a load still in EX cannot be bypassed; ID must wait one cycle
  always_comb begin
    hz = id_valid & ex_valid & ex_mem_read & (rd_q != '0) &
         ((rd_q == id_rs) | (rd_q == id_rt));
  end

  // Bypass selection, younger EX/MEM result beats MEM/WB; r0 is never bypassed
  always_comb begin
    fwd_a = rs_data_q;
    fwd_b = rt_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
      fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
      fwd_a = memwb_result;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
      fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
      fwd_b = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, mem_read_q};

  // Without bypass, any pending write in EX or EX/MEM to a source must drain first;
  // MEM/WB is covered by the write-before-read register file
  always_comb begin
    hz = id_valid &
         ((ex_valid & ex_reg_write & (rd_q != '0) & ((rd_q == id_rs) | (rd_q == id_rt))) |
          (exmem_reg_write & (exmem_rd != '0) & ((exmem_rd == id_rs) | (exmem_rd == id_rt))));
  end

  // Operands come straight from the captured register-file data
  always_comb begin
    fwd_a = rs_data_q;
    fwd_b = rt_data_q;
  end
`endif

  // Pipeline register: flush and hazard both insert a bubble, otherwise capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
    end else if (flush || hz) begin
      valid_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
    end else begin
      valid_q       <= id_valid;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      rd_q          <= id_rd;
      imm_q         <= imm_ext;
      alu_control_q <= id_alu_control;
      alu_src_q     <= id_alu_src;
      mem_read_q    <= id_mem_read;
      mem_write_q   <= id_mem_write;
      reg_write_q   <= id_reg_write;
      mem_to_reg_q  <= id_mem_to_reg;
    end
  end

  // Output drive; control is gated by valid so an invalid slot never writes
  always_comb begin
    stall          = hz;
    ex_valid       = valid_q;
    ex_alu_control = alu_control_q;
    ex_rd          = rd_q;
    ex_mem_read    = mem_read_q & valid_q;
    ex_mem_write   = mem_write_q & valid_q;
    ex_reg_write   = reg_write_q & valid_q;
    ex_mem_to_reg  = mem_to_reg_q & valid_q;
    alu_in1        = fwd_a;
    alu_in2        = alu_src_q ? imm_q : fwd_b;
    ex_store_data  = fwd_b;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Expectations follow IDEX_FORWARD_EN when it is defined for the build.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_rs_data;
  logic [15:0] id_rt_data;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic [2:0]  id_rd;
  logic [7:0]  id_imm;
  logic [2:0]  id_alu_control;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic        stall;
  logic        ex_valid;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  ex_alu_control;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;

  int checks = 0;
  int passes = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .stall(stall),
    .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                               input logic [2:0] rd, input logic [15:0] a, input logic [15:0] b,
                               input logic [7:0] imm, input logic [2:0] op, input logic src,
                               input logic mr, input logic mw, input logic rw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = a; id_rt_data = b; id_imm = imm; id_alu_control = op;
    id_alu_src = src; id_mem_read = mr; id_mem_write = mw;
    id_reg_write = rw; id_mem_to_reg = m2r;
    #1;
  endtask

  task automatic clearBypass();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; flush = 0;
    clearBypass();
    applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 8'h0, 3'b000, 0, 0, 0, 0, 0);
    #12;
    checkOutput("reset ex_valid", {15'b0, ex_valid}, 16'h0);
    checkOutput("reset stall", {15'b0, stall}, 16'h0);
    @(negedge clk);
    rst_n = 1;

    // Pass-through
    applyStimulus(1, 3'd1, 3'd2, 3'd4, 16'h0005, 16'h0003, 8'h00, 3'b001, 0, 0, 0, 1, 0);
    tick();
    checkOutput("pass ex_valid", {15'b0, ex_valid}, 16'h1);
    checkOutput("pass alu_in1", alu_in1, 16'h0005);
    checkOutput("pass alu_in2", alu_in2, 16'h0003);
    checkOutput("pass alu_ctl", {13'b0, ex_alu_control}, 16'h0001);
    checkOutput("pass ex_rd", {13'b0, ex_rd}, 16'h0004);
    checkOutput("pass stall", {15'b0, stall}, 16'h0);

    // Immediates: sign-extend vs LUI zero-extend
    applyStimulus(1, 3'd1, 3'd2, 3'd5, 16'h0005, 16'h0003, 8'h80, 3'b000, 1, 0, 0, 1, 0);
    tick();
    checkOutput("imm sext", alu_in2, 16'hFF80);
    checkOutput("imm store", ex_store_data, 16'h0003);
    applyStimulus(1, 3'd1, 3'd2, 3'd5, 16'h0005, 16'h0003, 8'h80, 3'b110, 1, 0, 0, 1, 0);
    tick();
    checkOutput("imm lui", alu_in2, 16'h0080);

    // Forward priority (ID idle so no stall interferes)
    applyStimulus(1, 3'd2, 3'd3, 3'd6, 16'h00AA, 16'h00BB, 8'h00, 3'b010, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 8'h00, 3'b000, 0, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd = 3'd2; exmem_result = 16'h1111;
    memwb_reg_write = 1; memwb_rd = 3'd2; memwb_result = 16'h2222;
    #1;
`ifdef IDEX_FORWARD_EN
    checkOutput("fwd exmem", alu_in1, 16'h1111);
`else
    checkOutput("fwd exmem", alu_in1, 16'h00AA);
`endif
    exmem_reg_write = 0;
    #1;
`ifdef IDEX_FORWARD_EN
    checkOutput("fwd memwb", alu_in1, 16'h2222);
`else
    checkOutput("fwd memwb", alu_in1, 16'h00AA);
`endif
    exmem_reg_write = 1; exmem_rd = 3'd0; memwb_rd = 3'd0;
    #1;
    checkOutput("fwd r0", alu_in1, 16'h00AA);
    exmem_rd = 3'd3;
    #1;
`ifdef IDEX_FORWARD_EN
    checkOutput("fwd store", ex_store_data, 16'h1111);
`else
    checkOutput("fwd store", ex_store_data, 16'h00BB);
`endif
    clearBypass();

    // Load-use: lw r3 in EX, consumer reads rt=3
    applyStimulus(1, 3'd1, 3'd0, 3'd3, 16'h0010, 16'h0, 8'h04, 3'b000, 1, 1, 0, 1, 1);
    tick();
    applyStimulus(1, 3'd4, 3'd3, 3'd7, 16'h0040, 16'h0030, 8'h00, 3'b001, 0, 0, 0, 1, 0);
    checkOutput("lu stall", {15'b0, stall}, 16'h1);
    tick();
    checkOutput("lu bubble valid", {15'b0, ex_valid}, 16'h0);
    checkOutput("lu bubble ctl", {12'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}, 16'h0);
    checkOutput("lu bubble stall", {15'b0, stall}, 16'h0);
    tick();
    checkOutput("lu recapture valid", {15'b0, ex_valid}, 16'h1);
    checkOutput("lu recapture rd", {13'b0, ex_rd}, 16'h0007);
    checkOutput("lu recapture rw", {15'b0, ex_reg_write}, 16'h1);
    checkOutput("lu recapture stall", {15'b0, stall}, 16'h0);

    // Non-load producer in EX (add r7), consumer reads r7
    applyStimulus(1, 3'd7, 3'd1, 3'd2, 16'h0001, 16'h0002, 8'h00, 3'b001, 0, 0, 0, 1, 0);
`ifdef IDEX_FORWARD_EN
    checkOutput("add dep stall", {15'b0, stall}, 16'h0);
`else
    checkOutput("add dep stall", {15'b0, stall}, 16'h1);
`endif
    flush = 1;
    tick();
    flush = 0;
    checkOutput("flush valid", {15'b0, ex_valid}, 16'h0);
    checkOutput("flush rw", {15'b0, ex_reg_write}, 16'h0);

    // EX/MEM producer only
    exmem_reg_write = 1; exmem_rd = 3'd2;
    applyStimulus(1, 3'd2, 3'd0, 3'd1, 16'h0, 16'h0, 8'h00, 3'b001, 0, 0, 0, 1, 0);
`ifdef IDEX_FORWARD_EN
    checkOutput("exmem dep stall", {15'b0, stall}, 16'h0);
`else
    checkOutput("exmem dep stall", {15'b0, stall}, 16'h1);
`endif
    clearBypass();

    // Reset mid-stall
    applyStimulus(1, 3'd1, 3'd0, 3'd3, 16'h0010, 16'h0, 8'h04, 3'b000, 1, 1, 0, 1, 1);
    tick();
    applyStimulus(1, 3'd4, 3'd3, 3'd7, 16'h0040, 16'h0030, 8'h00, 3'b001, 0, 0, 0, 1, 0);
    checkOutput("rst pre stall", {15'b0, stall}, 16'h1);
    #1 rst_n = 0;
    #1;
    checkOutput("rst stall", {15'b0, stall}, 16'h0);
    checkOutput("rst valid", {15'b0, ex_valid}, 16'h0);
    checkOutput("rst alu_in1", alu_in1, 16'h0);
    checkOutput("rst ex_rd", {13'b0, ex_rd}, 16'h0);
    checkOutput("rst mem_read", {15'b0, ex_mem_read}, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 16-bit pipeline.
- Captures decoded operands and control from ID. Drives the registered ALU control and the forwarded ALU operands directly into the ALU inputs.
- Detects load-use hazards and requests an ID/IF stall.

Parameters:
- DW, 16, datapath width
- RAW_, 3, register address width (8 registers; r0 reads as zero)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data  in  DW  register-file read data A
- id_rt_data  in  DW  register-file read data B
- id_rs, id_rt, id_rd  in  RAW_ each  source/destination register addresses
- id_imm  in  8  raw immediate field
- id_alu_control  in  3  ALU op code
- id_alu_src  in  1  1 selects immediate for operand B
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control bits
- flush  in  1  branch taken; kill the instruction entering ID/EX
- exmem_reg_write  in  1  EX/MEM stage writes a register
- exmem_rd  in  RAW_  EX/MEM destination register
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB stage writes a register
- memwb_rd  in  RAW_  MEM/WB destination register
- memwb_result  in  DW  MEM/WB write-back data
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  registered valid
- alu_in1, alu_in2  out  DW each  forwarded ALU operands (combinational from registers and bypass inputs)
- ex_alu_control  out  3  registered ALU op
- ex_store_data  out  DW  forwarded rt value for stores
- ex_rd  out  RAW_  registered destination register
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control; forced 0 when ex_valid is 0

Behaviour:
- Reset (async, rst_n=0): all registered fields 0, ex_valid=0, so all registered outputs are 0; stall=0.
- Immediate: zero-extended to DW when id_alu_control==3'b110 (LUI); otherwise sign-extended from bit 7. The extension is registered as imm_q.
- Load-use hazard: hz = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt). stall = hz.
- Register update each posedge, priority order:
  1. flush: ex_valid<=0, all control bits<=0.
  2. hz: insert bubble, same as flush. The ID instruction is re-presented next cycle because the upstream stage holds on stall.
  3. Otherwise: capture all id_* fields; ex_valid<=id_valid.
- Bubbles never assert memory or reg-write control.
- Forwarding for operand A (rs), priority highest first:
  - EX/MEM when exmem_reg_write & exmem_rd!=0 & exmem_rd==rs_q;
  - else MEM/WB when memwb_reg_write & memwb_rd!=0 & memwb_rd==rs_q;
  - else rs_data_q.
- Same rule for rt gives fwd_b.
- alu_in1 = fwd_a. alu_in2 = alu_src_q ? imm_q : fwd_b. ex_store_data = fwd_b always.
- Register r0 is never forwarded. A source address of 0 always uses the registered data, which the register file supplies as 0.
- Latency: one cycle from ID capture to operands at the ALU. Forwarding paths are zero-cycle combinational.
- Simultaneous flush and hz: flush wins. stall still equals hz, and the upstream stage gives flush precedence.
- Reset mid-stall: outputs clear immediately; stall drops because ex_valid=0.

Optional Feature:
- Macro IDEX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - alu_in1/alu_in2/ex_store_data use registered register-file data only.
  - Hazard detection widens to: hz = id_valid & [(ex_valid & ex_reg_write & ex_rd!=0 & ex_rd matches id_rs/id_rt) | (exmem_reg_write & exmem_rd!=0 & exmem_rd matches id_rs/id_rt)].
  - The register file is write-before-read, so MEM/WB needs no stall.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 immediately, stall=0.
- Pass-through: id_valid=1, rs_data=0x0005, rt_data=0x0003, alu_control=001, alu_src=0, no matching bypass -> next cycle alu_in1=0x0005, alu_in2=0x0003, ex_alu_control=001, ex_valid=1.
- Forward priority: rs_q=2, exmem_rd=2 result 0x1111, memwb_rd=2 result 0x2222, both reg_write=1 -> alu_in1=0x1111. Clear exmem_reg_write -> 0x2222. Set rd=0 on both -> registered data.
- Immediates: id_imm=0x80 with alu_src=1, op=000 -> alu_in2=0xFF80. Same with op=110 -> alu_in2=0x0080.
- Load-use: EX holds lw to r3 (mem_read=1); ID reads rt=3 -> stall=1 and next cycle ex_valid=0 with all control 0. Following cycle the re-presented instruction is captured and stall=0.
- Flush over hazard: hz=1 and flush=1 together -> bubble inserted, ex_reg_write=0. Without IDEX_FORWARD_EN: add r1 in EX, ID reads r1 -> stall=1.
